// File: rtl/apb_ram_param_pkg.sv
// Shared types and helpers for the parametrised APB4 completer RAM.
package apb_ram_param_pkg;

  // Transfer sequencing: IDLE waits for an ACCESS phase, WAIT burns programmed
  // wait states, RESP drives the single-cycle completion.
  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } apb_state_e;

  localparam logic APB_OKAY = 1'b0;
  localparam logic APB_ERR  = 1'b1;

  // Widest supported bus; narrower instances truncate the helper result.
  localparam int unsigned MaxDataW = 64;
  localparam int unsigned MaxStrbW = MaxDataW / 8;

  // Expand byte strobes into a per-bit write mask.
  function automatic logic [MaxDataW-1:0] strb_mask(input logic [MaxStrbW-1:0] strb);
    logic [MaxDataW-1:0] mask;
    mask = '0;
    for (int k = 0; k < MaxStrbW; k++) begin
      mask[8*k +: 8] = {8{strb[k]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/apb_ram_param_if.sv
// APB4 bus bundle with byte strobes, sized by data and address width.
interface apb_ram_param_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [StrbWidth-1:0]  pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel,
    output penable,
    output pwrite,
    output paddr,
    output pwdata,
    output pstrb,
    input  prdata,
    input  pready,
    input  pslverr
  );

  modport slave (
    input  psel,
    input  penable,
    input  pwrite,
    input  paddr,
    input  pwdata,
    input  pstrb,
    output prdata,
    output pready,
    output pslverr
  );

endinterface

// File: rtl/apb_ram_param_mem.sv
// DEPTH x DATA_WIDTH storage: bit-masked write, registered read, no reset.
module apb_ram_param_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned MemAw      = 5
) (
  input  logic                  pclk,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [MemAw-1:0]      addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] wmask_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Masked write merges new bytes into the stored word; read is captured on re_i.
  always_ff @(posedge pclk) begin
    if (we_i) begin
      mem_q[addr_i] <= (mem_q[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_ram_param.sv
// Parametrised APB4 completer RAM with byte strobes, programmable wait states
// and PSLVERR on misaligned or out-of-range accesses.
module apb_ram_param
  import apb_ram_param_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic            pclk,
  input logic            presetn,
  apb_ram_param_if.slave bus
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned OffWidth  = $clog2(StrbWidth);
  localparam int unsigned MemAw     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] OffMask =
      ADDR_WIDTH'((64'd1 << OffWidth) - 64'd1);
  // The first ACCESS cycle is spent in IDLE, so WAIT only covers the remaining
  // WAIT_STATES cycles; the counter therefore starts one lower.
  localparam logic [3:0] CntInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  apb_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pready_q, pready_d;
  logic       pslverr_q, pslverr_d;
  logic       rd_ok_q, rd_ok_d;

  logic                  access;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] widx;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  access_err;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_wmask;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign access = bus.psel & bus.penable;

  // Address decode: word index plus alignment and range checks.
  always_comb begin
    widx         = bus.paddr >> OffWidth;
    misaligned   = |(bus.paddr & OffMask);
    out_of_range = widx >= ADDR_WIDTH'(DEPTH);
    access_err   = misaligned | out_of_range;
  end

  // Next-state logic; commit marks the edge that enters RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access && !pready_q) begin
          if (WAIT_STATES == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (!access) begin
          // Master abandoned the transfer: nothing is committed or answered.
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Response flags are set only for the cycle following a commit.
  always_comb begin
    pready_d  = commit;
    pslverr_d = (commit && access_err) ? APB_ERR : APB_OKAY;
    rd_ok_d   = commit & ~bus.pwrite & ~access_err;
    mem_we    = commit & bus.pwrite & ~access_err;
    mem_re    = commit & ~bus.pwrite & ~access_err;
    mem_wmask = DATA_WIDTH'(strb_mask(MaxStrbW'(bus.pstrb)));
  end

  // FSM, wait counter and response registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= APB_OKAY;
      rd_ok_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      rd_ok_q   <= rd_ok_d;
    end
  end

  apb_ram_param_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .MemAw      (MemAw)
  ) u_mem (
    .pclk    (pclk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (widx[MemAw-1:0]),
    .wdata_i (bus.pwdata),
    .wmask_i (mem_wmask),
    .rdata_o (mem_rdata)
  );

  // Read data is gated so prdata is zero outside a successful read response.
  assign bus.prdata  = rd_ok_q ? mem_rdata : '0;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_ram_param.sv
// Bench for apb_ram_param: three instances (32-bit/0 waits, 32-bit/3 waits,
// 64-bit/depth 16) driven from a shared stimulus bus, checked against a
// byte-level memory model.
module tb_apb_ram_param;

  localparam int unsigned NDUT = 3;

  logic        pclk;
  logic        presetn;
  logic [1:0]  tgt;
  logic        psel, penable, pwrite;
  logic [31:0] paddr;
  logic [63:0] pwdata;
  logic [7:0]  pstrb;
  logic [63:0] prdata_m;
  logic        pready_m, pslverr_m;

  int n_checks;
  int n_fail;
  logic [63:0] model [NDUT][32];

  apb_ram_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
  apb_ram_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();
  apb_ram_param_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus2 ();

  assign bus0.psel    = psel && (tgt == 2'd0);
  assign bus0.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus0.paddr   = paddr;
  assign bus0.pwdata  = pwdata[31:0];
  assign bus0.pstrb   = pstrb[3:0];
  assign bus1.psel    = psel && (tgt == 2'd1);
  assign bus1.penable = penable;
  assign bus1.pwrite  = pwrite;
  assign bus1.paddr   = paddr;
  assign bus1.pwdata  = pwdata[31:0];
  assign bus1.pstrb   = pstrb[3:0];
  assign bus2.psel    = psel && (tgt == 2'd2);
  assign bus2.penable = penable;
  assign bus2.pwrite  = pwrite;
  assign bus2.paddr   = paddr;
  assign bus2.pwdata  = pwdata;
  assign bus2.pstrb   = pstrb;

  always_comb begin
    prdata_m  = '0;
    pready_m  = 1'b0;
    pslverr_m = 1'b0;
    case (tgt)
      2'd0: begin
        prdata_m = {32'b0, bus0.prdata}; pready_m = bus0.pready; pslverr_m = bus0.pslverr;
      end
      2'd1: begin
        prdata_m = {32'b0, bus1.prdata}; pready_m = bus1.pready; pslverr_m = bus1.pslverr;
      end
      default: begin
        prdata_m = bus2.prdata; pready_m = bus2.pready; pslverr_m = bus2.pslverr;
      end
    endcase
  end

  apb_ram_param #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_STATES(0)) dut0 (
    .pclk(pclk), .presetn(presetn), .bus(bus0)
  );
  apb_ram_param #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_STATES(3)) dut1 (
    .pclk(pclk), .presetn(presetn), .bus(bus1)
  );
  apb_ram_param #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) dut2 (
    .pclk(pclk), .presetn(presetn), .bus(bus2)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---- reference model ----
  function automatic int unsigned nbytes(input int t);
    return (t == 2) ? 8 : 4;
  endfunction

  function automatic int unsigned depth(input int t);
    return (t == 2) ? 16 : 32;
  endfunction

  // pready arrives in ACCESS cycle WAIT_STATES+2
  function automatic int lat(input int t);
    return ((t == 1) ? 3 : 0) + 2;
  endfunction

  function automatic logic expect_err(input int t, input logic [31:0] a);
    return ((a % nbytes(t)) != 0) || ((a / nbytes(t)) >= depth(t));
  endfunction

  function automatic logic [63:0] model_read(input int t, input logic [31:0] a);
    if (expect_err(t, a)) return 64'd0;
    return model[t][a / nbytes(t)];
  endfunction

  function automatic void model_write(input int t, input logic [31:0] a,
                                      input logic [63:0] wd, input logic [7:0] st);
    int unsigned w;
    if (expect_err(t, a)) return;
    w = a / nbytes(t);
    for (int k = 0; k < int'(nbytes(t)); k++) begin
      if (st[k]) model[t][w][8*k +: 8] = wd[8*k +: 8];
    end
  endfunction

  function automatic logic [31:0] rand_addr(input int t);
    int unsigned nb;
    int unsigned dp;
    nb = nbytes(t);
    dp = depth(t);
    case ($urandom_range(0, 9))
      7:       return (dp + $urandom_range(0, 20)) * nb;
      8:       return $urandom_range(0, dp - 1) * nb + $urandom_range(1, nb - 1);
      9:       return $urandom;
      default: return $urandom_range(0, dp - 1) * nb;
    endcase
  endfunction

  // ---- bus driver ----
  // Runs SETUP then ACCESS; returns at the negedge of the pready cycle (bus left
  // in ACCESS) or after the cycle budget. rdy_cyc = 0 means no pready seen.
  task automatic xfer(input int t, input logic wr, input logic [31:0] a,
                      input logic [63:0] wd, input logic [7:0] st, input int abort_at,
                      output int rdy_cyc, output logic [63:0] rd, output logic err,
                      output logic setup_busy);
    @(posedge pclk); #1;
    tgt = 2'(t); psel = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(negedge pclk);
    setup_busy = pready_m | pslverr_m | (prdata_m != 64'd0);
    @(posedge pclk); #1;
    penable = 1'b1;
    rdy_cyc = 0; rd = '0; err = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (abort_at == cyc) begin
        psel = 1'b0; penable = 1'b0;
      end
      @(negedge pclk);
      if (pready_m) begin
        rdy_cyc = cyc; rd = prdata_m; err = pslverr_m;
        break;
      end
      @(posedge pclk); #1;
    end
  endtask

  task automatic bus_idle();
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // ---- tests ----
  task automatic test_reset();
    presetn = 1'b0; tgt = 2'd0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    n_checks++;
    if ({bus0.pready, bus0.pslverr, bus0.prdata} !== 34'd0) begin
      n_fail++; $display("FAIL reset_dut0: got %h expected 0", {bus0.pready, bus0.pslverr, bus0.prdata});
    end
    n_checks++;
    if ({bus1.pready, bus1.pslverr, bus1.prdata} !== 34'd0) begin
      n_fail++; $display("FAIL reset_dut1: got %h expected 0", {bus1.pready, bus1.pslverr, bus1.prdata});
    end
    n_checks++;
    if ({bus2.pready, bus2.pslverr, bus2.prdata} !== 66'd0) begin
      n_fail++; $display("FAIL reset_dut2: got %h expected 0", {bus2.pready, bus2.pslverr, bus2.prdata});
    end
    presetn = 1'b1;
  endtask

  task automatic test_fill();
    int rdy; logic [63:0] rd, wd; logic err, busy; logic [31:0] a;
    for (int t = 0; t < int'(NDUT); t++) begin
      for (int w = 0; w < int'(depth(t)); w++) begin
        a = 32'(w) * nbytes(t);
        wd = {$urandom, $urandom};
        xfer(t, 1'b1, a, wd, 8'hFF, 0, rdy, rd, err, busy);
        model_write(t, a, wd, 8'hFF);
        n_checks++;
        if (rdy !== lat(t) || err !== 1'b0) begin
          n_fail++;
          $display("FAIL fill t%0d a%h: got lat %0d err %b expected lat %0d err 0",
                   t, a, rdy, err, lat(t));
        end
      end
    end
    bus_idle();
  endtask

  task automatic test_basic();
    int rdy; logic [63:0] rd; logic err, busy;
    xfer(0, 1'b1, 32'h4, 64'hDEADBEEF, 8'h0F, 0, rdy, rd, err, busy);
    model_write(0, 32'h4, 64'hDEADBEEF, 8'h0F);
    n_checks++;
    if (rdy !== 2 || err !== 1'b0) begin
      n_fail++; $display("FAIL basic_wr: got lat %0d err %b expected lat 2 err 0", rdy, err);
    end
    xfer(0, 1'b0, 32'h4, 64'd0, 8'h0, 0, rdy, rd, err, busy);
    n_checks++;
    if (rdy !== 2 || err !== 1'b0) begin
      n_fail++; $display("FAIL basic_rd: got lat %0d err %b expected lat 2 err 0", rdy, err);
    end
    n_checks++;
    if (rd !== 64'hDEADBEEF) begin
      n_fail++; $display("FAIL basic_rdata: got %h expected deadbeef", rd);
    end
    bus_idle();
  endtask

  task automatic test_strobes();
    int rdy; logic [63:0] rd; logic err, busy;
    xfer(0, 1'b1, 32'h8, 64'h11223344, 8'h0F, 0, rdy, rd, err, busy);
    model_write(0, 32'h8, 64'h11223344, 8'h0F);
    xfer(0, 1'b1, 32'h8, 64'hAABBCCDD, 8'h05, 0, rdy, rd, err, busy);
    model_write(0, 32'h8, 64'hAABBCCDD, 8'h05);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL strb_wr_err: got %b expected 0", err);
    end
    xfer(0, 1'b1, 32'h8, 64'h99999999, 8'h00, 0, rdy, rd, err, busy);
    n_checks++;
    if (rdy !== 2 || err !== 1'b0) begin
      n_fail++; $display("FAIL strb_zero: got lat %0d err %b expected lat 2 err 0", rdy, err);
    end
    xfer(0, 1'b0, 32'h8, 64'd0, 8'h0, 0, rdy, rd, err, busy);
    n_checks++;
    if (rd !== 64'h11BB33DD) begin
      n_fail++; $display("FAIL strb_rdata: got %h expected 11bb33dd", rd);
    end
    bus_idle();
  endtask

  task automatic test_errors();
    int rdy; logic [63:0] rd; logic err, busy;
    xfer(0, 1'b0, 32'h80, 64'd0, 8'h0, 0, rdy, rd, err, busy);
    n_checks++;
    if (rdy !== 2 || err !== 1'b1 || rd !== 64'd0) begin
      n_fail++; $display("FAIL err_range: got lat %0d err %b rd %h expected 2 1 0", rdy, err, rd);
    end
    xfer(0, 1'b1, 32'h6, 64'h55555555, 8'h0F, 0, rdy, rd, err, busy);
    n_checks++;
    if (rdy !== 2 || err !== 1'b1) begin
      n_fail++; $display("FAIL err_misalign: got lat %0d err %b expected 2 1", rdy, err);
    end
    xfer(0, 1'b0, 32'h4, 64'd0, 8'h0, 0, rdy, rd, err, busy);
    n_checks++;
    if (rd !== 64'hDEADBEEF || err !== 1'b0) begin
      n_fail++; $display("FAIL err_untouched: got %h err %b expected deadbeef 0", rd, err);
    end
    bus_idle();
  endtask

  task automatic test_wait_states();
    int rdy; logic [63:0] rd; logic err, busy;
    xfer(1, 1'b0, 32'h20, 64'd0, 8'h0, 0, rdy, rd, err, busy);
    n_checks++;
    if (rdy !== 5) begin
      n_fail++; $display("FAIL ws_latency: got cycle %0d expected 5", rdy);
    end
    n_checks++;
    if (rd !== model_read(1, 32'h20)) begin
      n_fail++; $display("FAIL ws_rdata: got %h expected %h", rd, model_read(1, 32'h20));
    end
    bus_idle();
    @(negedge pclk);
    n_checks++;
    if ({pready_m, pslverr_m, prdata_m} !== 66'd0) begin
      n_fail++; $display("FAIL ws_resp_len: got %h expected 0", {pready_m, pslverr_m, prdata_m});
    end
    xfer(1, 1'b1, 32'h0C, 64'h0BADF00D, 8'hFF, 3, rdy, rd, err, busy);
    n_checks++;
    if (rdy !== 0) begin
      n_fail++; $display("FAIL ws_abort_ready: got cycle %0d expected none", rdy);
    end
    xfer(1, 1'b0, 32'h0C, 64'd0, 8'h0, 0, rdy, rd, err, busy);
    n_checks++;
    if (rd !== model_read(1, 32'h0C)) begin
      n_fail++; $display("FAIL ws_abort_mem: got %h expected %h", rd, model_read(1, 32'h0C));
    end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    int rdy; logic [63:0] rd; logic err, busy;
    xfer(1, 1'b1, 32'h10, 64'hCAFEF00D, 8'h0F, 0, rdy, rd, err, busy);
    model_write(1, 32'h10, 64'hCAFEF00D, 8'h0F);
    bus_idle();
    @(posedge pclk); #1;
    tgt = 2'd1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h10; pwdata = 64'h12345678; pstrb = 8'hFF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    #2 presetn = 1'b0;
    #1;
    n_checks++;
    if ({bus1.pready, bus1.pslverr, bus1.prdata} !== 34'd0) begin
      n_fail++; $display("FAIL rst_wait_out: got %h expected 0", {bus1.pready, bus1.pslverr, bus1.prdata});
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    xfer(1, 1'b0, 32'h10, 64'd0, 8'h0, 0, rdy, rd, err, busy);
    n_checks++;
    if (rdy !== 5 || rd !== 64'hCAFEF00D) begin
      n_fail++; $display("FAIL rst_lost_write: got lat %0d rd %h expected 5 cafef00d", rdy, rd);
    end
    // Reset asserted while a read response is on the bus must clear it at once.
    #2 presetn = 1'b0;
    #1;
    n_checks++;
    if ({pready_m, pslverr_m, prdata_m} !== 66'd0) begin
      n_fail++; $display("FAIL rst_async: got %h expected 0", {pready_m, pslverr_m, prdata_m});
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    xfer(1, 1'b0, 32'h10, 64'd0, 8'h0, 0, rdy, rd, err, busy);
    n_checks++;
    if (rd !== 64'hCAFEF00D || err !== 1'b0) begin
      n_fail++; $display("FAIL rst_retained: got %h err %b expected cafef00d 0", rd, err);
    end
    bus_idle();
  endtask

  task automatic test_wide();
    int rdy; logic [63:0] rd, wd; logic err, busy;
    wd = {$urandom, $urandom};
    xfer(2, 1'b1, 32'h78, wd, 8'hFF, 0, rdy, rd, err, busy);
    model_write(2, 32'h78, wd, 8'hFF);
    n_checks++;
    if (rdy !== 2 || err !== 1'b0) begin
      n_fail++; $display("FAIL wide_wr: got lat %0d err %b expected 2 0", rdy, err);
    end
    xfer(2, 1'b0, 32'h78, 64'd0, 8'h0, 0, rdy, rd, err, busy);
    n_checks++;
    if (rd !== wd) begin
      n_fail++; $display("FAIL wide_rdata: got %h expected %h", rd, wd);
    end
    xfer(2, 1'b0, 32'h80, 64'd0, 8'h0, 0, rdy, rd, err, busy);
    n_checks++;
    if (err !== 1'b1 || rd !== 64'd0) begin
      n_fail++; $display("FAIL wide_range: got err %b rd %h expected 1 0", err, rd);
    end
    xfer(2, 1'b1, 32'h7C, ~wd, 8'hFF, 0, rdy, rd, err, busy);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL wide_misalign: got err %b expected 1", err);
    end
    xfer(2, 1'b0, 32'h78, 64'd0, 8'h0, 0, rdy, rd, err, busy);
    n_checks++;
    if (rd !== wd) begin
      n_fail++; $display("FAIL wide_untouched: got %h expected %h", rd, wd);
    end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    int rdy; logic [63:0] rd, wd; logic err, busy; logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      a = 32'($urandom_range(0, 31)) * 4;
      wd = {32'd0, $urandom};
      xfer(0, 1'b1, a, wd, 8'h0F, 0, rdy, rd, err, busy);
      model_write(0, a, wd, 8'h0F);
      xfer(0, 1'b0, a, 64'd0, 8'h0, 0, rdy, rd, err, busy);
      n_checks++;
      if (busy !== 1'b0 || rdy !== 2 || rd !== model_read(0, a)) begin
        n_fail++;
        $display("FAIL b2b a%h: got busy %b lat %0d rd %h expected 0 2 %h",
                 a, busy, rdy, rd, model_read(0, a));
      end
    end
    bus_idle();
  endtask

  task automatic test_random();
    int rdy; int t; logic [63:0] rd, wd, exp_rd; logic err, busy, exp_err, wr;
    logic [31:0] a; logic [7:0] st;
    for (int i = 0; i < 150; i++) begin
      t = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      a = rand_addr(t);
      wd = {$urandom, $urandom};
      st = 8'($urandom);
      exp_err = expect_err(t, a);
      exp_rd = model_read(t, a);
      xfer(t, wr, a, wd, st, 0, rdy, rd, err, busy);
      if (wr) model_write(t, a, wd, st);
      n_checks++;
      if (rdy !== lat(t) || err !== exp_err || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d t%0d a%h: got lat %0d err %b busy %b expected %0d %b 0",
                 i, t, a, rdy, err, busy, lat(t), exp_err);
      end
      if (!wr) begin
        n_checks++;
        if (rd !== exp_rd) begin
          n_fail++; $display("FAIL rand%0d_rdata t%0d a%h: got %h expected %h", i, t, a, rd, exp_rd);
        end
      end
      if ($urandom_range(0, 3) == 0) bus_idle();
    end
    bus_idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_fill();
    test_basic();
    test_strobes();
    test_errors();
    test_wait_states();
    test_reset_mid();
    test_wide();
    test_back_to_back();
    test_random();
    repeat (2) @(posedge pclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
